axis_packet_merger: RTL and testbench
=====================================

AXIS_PACKET_MERGER -- requirements
Module: axis_packet_merger

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_WIDTH, 16, tdata width.
- KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep.
- KEEP_WIDTH, ceil(DATA_WIDTH/8) or 1, tkeep width.
- ID_ENABLE/ID_WIDTH, 0/1, tid.
- DEST_ENABLE/DEST_WIDTH, 0/1, tdest.
- USER_ENABLE/USER_WIDTH, 0/1, tuser.
- PCKT_WIDTH, 32, packet-count width.
REQ-002 Ports SHALL be (name direction width meaning):
- clk in 1: single clock, rising edge.
- rst in 1: reset, asynchronous, active-high.
- operation_start in 1: arm merge.
- pckt_count in PCKT_WIDTH: input packets merged into one output packet.
- lock in 1: freeze input acceptance.
- external_error in 1: abort.
- operation_busy, operation_complete, operation_error out 1: status.
- transmission out 1: input beat accepted this cycle.
- s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser: AXI-Stream sink, widths per parameters.
- m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser: AXI-Stream source, widths per parameters.

Function
REQ-003 FSM SHALL have states IDLE, RUN, DRAIN, DONE, ERROR.
REQ-004 In IDLE, operation_start=1 SHALL latch pckt_count and clear the packet counter; next state is RUN if pckt_count!=0, else ERROR.
REQ-005 operation_start SHALL be ignored in RUN and DRAIN.
REQ-006 The output SHALL be one register stage: s_axis_tready = (state==RUN) & ~lock & (~m_axis_tvalid | m_axis_tready); latency 1 cycle; full throughput with no back-pressure.
REQ-007 Each accepted beat SHALL load tdata/tkeep/tid/tdest/tuser unchanged into the output register.
- Disabled tkeep SHALL drive all ones.
- Disabled tid/tdest/tuser SHALL drive zero.
REQ-008 Input tlast SHALL increment the packet counter.
- m_axis_tlast SHALL be 0 except on the beat whose tlast completes packet number pckt_count.
- That beat's tlast SHALL pass as 1, and the FSM SHALL enter DRAIN, where s_axis_tready=0.
REQ-009 DRAIN SHALL go to DONE in the cycle the final beat handshakes on m_axis.
- operation_complete SHALL be 1 for exactly one cycle in DONE, which then returns to IDLE.
REQ-010 operation_busy SHALL be 1 in RUN and DRAIN, else 0.
- transmission SHALL equal s_axis_tvalid & s_axis_tready.
REQ-011 external_error=1 in RUN or DRAIN SHALL enter ERROR next cycle.
- In ERROR: output register flushed (m_axis_tvalid=0), s_axis_tready=0, operation_error=1.
REQ-012 ERROR SHALL persist until operation_start, which re-arms exactly as REQ-004.
- external_error in IDLE or DONE SHALL be ignored.
REQ-013 lock=1 SHALL only stall input acceptance.
- The output register SHALL still drain, and counters and state SHALL hold.
REQ-014 Simultaneous external_error and the final input beat SHALL resolve to ERROR, with no operation_complete.
REQ-015 Counter compare SHALL be on PCKT_WIDTH bits, unsigned.
- pckt_count=2^PCKT_WIDTH-1 SHALL be legal.
- The counter SHALL never wrap, because the merge terminates at the match.

Reset
REQ-016 rst SHALL asynchronously force:
- state=IDLE; counter, latched count and output register cleared.
- m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=0.
- All status outputs 0.
REQ-017 rst mid-operation SHALL discard the in-flight beat without emitting tlast.
- After deassertion the block SHALL await a new operation_start.

Structure
REQ-018 A shared package SHALL hold the FSM state encoding and default widths (PCKT_WIDTH, DATA_WIDTH).
- The splitter SHALL use the same package.
REQ-019 One sub-module SHALL be used: axis_output_register (single-stage registered AXI-Stream slice).
- It SHALL provide a flush input, driven in ERROR.
REQ-020 A multi-channel wrapper is out of scope.

Verification
REQ-021 pckt_count=3, three 4-beat packets, m_axis_tready=1 -> 12 output beats, tlast only on beat 12, operation_complete one cycle after the last handshake.
REQ-022 Same stimulus, m_axis_tready toggling 1/0 -> identical data order, no beat lost or duplicated, single tlast.
REQ-023 pckt_count=0 with operation_start -> operation_error=1 next cycle, s_axis_tready stays 0.
REQ-024 pckt_count=1, single-beat packet with tlast -> one output beat with tlast=1, then complete.
REQ-025 external_error pulsed after beat 5 of a pckt_count=2 merge -> ERROR, m_axis_tvalid=0; a new operation_start with pckt_count=1 completes normally.
REQ-026 rst asserted mid-packet and also with lock=1 during RUN -> all outputs reset immediately; under lock, no input handshake occurs while lock=1.

Source files
------------

// File: rtl/axis_packet_merger_pkg.sv
`default_nettype none
// ============================================================================
// axis_packet_merger_pkg : shared FSM encoding and default widths
// Rev 1.0
// ============================================================================
package axis_packet_merger_pkg;

  localparam int c_DATA_WIDTH = 16;
  localparam int c_PCKT_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/axis_output_register.sv
`default_nettype none
// ============================================================================
// axis_output_register : single-stage registered AXI-Stream slice with flush
// Rev 1.0
// ============================================================================
module axis_output_register
  import axis_packet_merger_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_payload,
  input  logic             i_last,
  input  logic             i_ready,
  output logic             o_load_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_payload,
  output logic             o_last
);

  logic             r_valid;
  logic             r_last;
  logic [WIDTH-1:0] r_payload;

  // Flush wins over a same-cycle load so an aborted beat never surfaces.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_payload <= '0;
    end else if (i_flush) begin
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_payload <= '0;
    end else if (i_load) begin
      r_valid   <= 1'b1;
      r_last    <= i_last;
      r_payload <= i_payload;
    end else if (i_ready) begin
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
    end
  end

  assign o_load_ready = ~r_valid | i_ready;
  assign o_valid      = r_valid;
  assign o_last       = r_last;
  assign o_payload    = r_payload;

endmodule
`default_nettype wire

// File: rtl/axis_packet_merger.sv
`default_nettype none
// ============================================================================
// axis_packet_merger : merges pckt_count input packets into one output packet
// Rev 1.0
// ============================================================================
module axis_packet_merger
  import axis_packet_merger_pkg::*;
#(
  parameter int DATA_WIDTH  = c_DATA_WIDTH,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8) ? 1 : 0,
  parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 1,
  parameter int DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = 1,
  parameter int USER_ENABLE = 0,
  parameter int USER_WIDTH  = 1,
  parameter int PCKT_WIDTH  = c_PCKT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  operation_start,
  input  logic [PCKT_WIDTH-1:0] pckt_count,
  input  logic                  lock,
  input  logic                  external_error,
  output logic                  operation_busy,
  output logic                  operation_complete,
  output logic                  operation_error,
  output logic                  transmission,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser
);

  localparam int c_PW = DATA_WIDTH + KEEP_WIDTH + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  state_t                r_state;
  logic [PCKT_WIDTH-1:0] r_pckt_target;
  logic [PCKT_WIDTH-1:0] r_pckt_cnt;

  logic                  w_reg_ready;
  logic                  w_load;
  logic                  w_final;
  logic                  w_active;
  logic                  w_flush;
  logic [c_PW-1:0]       w_in_payload;
  logic [c_PW-1:0]       w_out_payload;
  logic [DATA_WIDTH-1:0] w_out_data;
  logic [KEEP_WIDTH-1:0] w_out_keep;
  logic [ID_WIDTH-1:0]   w_out_id;
  logic [DEST_WIDTH-1:0] w_out_dest;
  logic [USER_WIDTH-1:0] w_out_user;

  assign w_active      = (r_state == ST_RUN) | (r_state == ST_DRAIN);
  assign s_axis_tready = (r_state == ST_RUN) & ~lock & w_reg_ready;
  assign w_load        = s_axis_tvalid & s_axis_tready;
  assign transmission  = w_load;
  // Compare against target-1 so the counter never has to reach past the target.
  assign w_final       = s_axis_tlast & (r_pckt_cnt == (r_pckt_target - PCKT_WIDTH'(1)));
  assign w_flush       = (r_state == ST_ERROR) | (w_active & external_error);

  assign operation_busy     = w_active;
  assign operation_complete = (r_state == ST_DONE);
  assign operation_error    = (r_state == ST_ERROR);

  assign w_in_payload = {s_axis_tdata, s_axis_tkeep, s_axis_tid, s_axis_tdest, s_axis_tuser};
  assign {w_out_data, w_out_keep, w_out_id, w_out_dest, w_out_user} = w_out_payload;

  assign m_axis_tdata = w_out_data;
  assign m_axis_tkeep = (KEEP_ENABLE != 0) ? w_out_keep : {KEEP_WIDTH{1'b1}};
  assign m_axis_tid   = (ID_ENABLE != 0)   ? w_out_id   : '0;
  assign m_axis_tdest = (DEST_ENABLE != 0) ? w_out_dest : '0;
  assign m_axis_tuser = (USER_ENABLE != 0) ? w_out_user : '0;

  axis_output_register #(
    .WIDTH (c_PW)
  ) u_out_reg (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (w_flush),
    .i_load       (w_load),
    .i_payload    (w_in_payload),
    .i_last       (w_final),
    .i_ready      (m_axis_tready),
    .o_load_ready (w_reg_ready),
    .o_valid      (m_axis_tvalid),
    .o_payload    (w_out_payload),
    .o_last       (m_axis_tlast)
  );

  // External error outranks a coincident final beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pckt_target <= '0;
      r_pckt_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ERROR: begin
          if (operation_start) begin
            r_pckt_target <= pckt_count;
            r_pckt_cnt    <= '0;
            r_state       <= (pckt_count != '0) ? ST_RUN : ST_ERROR;
          end
        end
        ST_RUN: begin
          if (external_error) begin
            r_state <= ST_ERROR;
          end else if (w_load & s_axis_tlast) begin
            r_pckt_cnt <= r_pckt_cnt + PCKT_WIDTH'(1);
            if (w_final) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (external_error) r_state <= ST_ERROR;
          else if (m_axis_tvalid & m_axis_tready) r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_merger.sv
`default_nettype none
// ============================================================================
// tb_axis_packet_merger : directed scoreboard bench for axis_packet_merger
// Rev 1.0
// ============================================================================
module tb_axis_packet_merger;

  localparam int DW = 16;
  localparam int KW = 2;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          operation_start;
  logic [PW-1:0] pckt_count;
  logic          lock;
  logic          external_error;
  logic          operation_busy, operation_complete, operation_error, transmission;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [0:0]    s_axis_tid, s_axis_tdest, s_axis_tuser;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [0:0]    m_axis_tid, m_axis_tdest, m_axis_tuser;

  axis_packet_merger #(
    .DATA_WIDTH (DW),
    .KEEP_WIDTH (KW),
    .PCKT_WIDTH (PW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .operation_start    (operation_start),
    .pckt_count         (pckt_count),
    .lock               (lock),
    .external_error     (external_error),
    .operation_busy     (operation_busy),
    .operation_complete (operation_complete),
    .operation_error    (operation_error),
    .transmission       (transmission),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tkeep       (s_axis_tkeep),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tready      (s_axis_tready),
    .s_axis_tlast       (s_axis_tlast),
    .s_axis_tid         (s_axis_tid),
    .s_axis_tdest       (s_axis_tdest),
    .s_axis_tuser       (s_axis_tuser),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tkeep       (m_axis_tkeep),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .m_axis_tlast       (m_axis_tlast),
    .m_axis_tid         (m_axis_tid),
    .m_axis_tdest       (m_axis_tdest),
    .m_axis_tuser       (m_axis_tuser)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          out_beats = 0;
  int          out_lasts = 0;
  int          last_hs_cyc = 0;
  logic        rdy_toggle = 1'b0;
  logic        rdy_level = 1'b1;
  logic [18:0] sb[$];
  logic [18:0] mon_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc++;

  // Sink-side ready pattern: fixed level or alternating every cycle.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_toggle) m_axis_tready = ~m_axis_tready;
      else m_axis_tready = rdy_level;
    end
  end

  // Output monitor: every handshake pops the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      out_beats++;
      if (m_axis_tlast) begin
        out_lasts++;
        last_hs_cyc = cyc;
      end
      check("side_fields_zero", {m_axis_tid, m_axis_tdest, m_axis_tuser}, 0);
      if (sb.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        mon_exp = sb.pop_front();
        check("out_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, mon_exp);
      end
    end
  end

  task automatic start_op(input logic [PW-1:0] count);
    pckt_count      = count;
    operation_start = 1'b1;
    @(posedge clk);
    #1;
    operation_start = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                           input logic fin);
    logic accepted;
    accepted      = 1'b0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 64 && !accepted; i++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        sb.push_back({d, k, fin});
        check("transmission", transmission, 1);
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check("beat_accepted", accepted, 1);
  endtask

  task automatic send_packet(input int p, input int nb, input bit final_pkt);
    logic [7:0] pb;
    logic [7:0] bb;
    pb = p[7:0];
    for (int b = 0; b < nb; b++) begin
      bb = b[7:0];
      send_beat({pb ^ 8'hA5, bb}, (b == nb - 1) ? 2'b01 : 2'b11, (b == nb - 1),
                (b == nb - 1) && final_pkt);
    end
  endtask

  task automatic wait_complete(input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (operation_complete === 1'b1) found = 1'b1;
    end
    check("complete_seen", found, 1);
    check("complete_latency", cyc, last_hs_cyc + 1);
    @(negedge clk);
    check("complete_one_cycle", operation_complete, 0);
    check("busy_after_done", operation_busy, 0);
    check("scoreboard_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    operation_start = 1'b0;
    pckt_count = '0;
    lock = 1'b0;
    external_error = 1'b0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tid = '0;
    s_axis_tdest = '0;
    s_axis_tuser = '0;

    #12;
    check("rst_status", {operation_busy, operation_complete, operation_error}, 0);
    check("rst_m_valid_last", {m_axis_tvalid, m_axis_tlast}, 0);
    check("rst_s_ready", s_axis_tready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Three 4-beat packets merged, sink always ready.
    out_beats = 0; out_lasts = 0;
    start_op(3);
    @(negedge clk);
    check("busy_in_run", operation_busy, 1);
    @(posedge clk);
    #1;
    for (int p = 0; p < 3; p++) send_packet(p, 4, p == 2);
    wait_complete(50);
    check("beats_ready_high", out_beats, 12);
    check("lasts_ready_high", out_lasts, 1);

    // Same merge with alternating back-pressure.
    out_beats = 0; out_lasts = 0;
    rdy_toggle = 1'b1;
    start_op(3);
    for (int p = 0; p < 3; p++) send_packet(p + 8, 4, p == 2);
    wait_complete(100);
    rdy_toggle = 1'b0;
    check("beats_toggle", out_beats, 12);
    check("lasts_toggle", out_lasts, 1);

    // Zero count is an immediate error; no input is accepted.
    s_axis_tvalid = 1'b1;
    start_op(0);
    @(negedge clk);
    check("zero_count_error", operation_error, 1);
    check("zero_count_ready", s_axis_tready, 0);
    check("zero_count_xfer", transmission, 0);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;

    // Single-beat single packet.
    out_beats = 0; out_lasts = 0;
    start_op(1);
    send_packet(20, 1, 1'b1);
    wait_complete(50);
    check("single_beats", out_beats, 1);
    check("single_lasts", out_lasts, 1);

    // External error after beat 5 of a two-packet merge, then recovery.
    out_lasts = 0;
    start_op(2);
    send_packet(30, 4, 1'b0);
    send_beat(16'h7700, 2'b11, 1'b0, 1'b0);
    external_error = 1'b1;
    @(posedge clk);
    #1;
    external_error = 1'b0;
    @(negedge clk);
    check("abort_error", operation_error, 1);
    check("abort_m_valid", m_axis_tvalid, 0);
    check("abort_s_ready", s_axis_tready, 0);
    check("abort_sb_empty", sb.size(), 0);
    @(negedge clk);
    check("error_persists", operation_error, 1);
    @(posedge clk);
    #1;
    start_op(1);
    send_packet(40, 2, 1'b1);
    wait_complete(50);
    check("recover_error_clear", operation_error, 0);
    check("recover_lasts", out_lasts, 1);

    // Error coincident with final input beat: error wins, beat is discarded.
    start_op(1);
    s_axis_tdata = 16'hBEEF; s_axis_tkeep = 2'b11; s_axis_tlast = 1'b1;
    s_axis_tvalid = 1'b1; external_error = 1'b1;
    @(negedge clk);
    check("race_xfer", transmission, 1);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; external_error = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("race_error", operation_error, 1);
      check("race_no_complete", operation_complete, 0);
      check("race_m_valid", m_axis_tvalid, 0);
    end
    @(posedge clk);
    #1;

    // Lock stalls acceptance; reset under lock clears everything.
    start_op(1);
    lock = 1'b1;
    s_axis_tdata = 16'h1234; s_axis_tkeep = 2'b11; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lock_ready", s_axis_tready, 0);
      check("lock_xfer", transmission, 0);
    end
    check("lock_busy", operation_busy, 1);
    #2 rst = 1'b1;
    #1;
    check("lock_rst_status", {operation_busy, operation_complete, operation_error}, 0);
    check("lock_rst_ready", s_axis_tready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; lock = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;

    // Reset mid-packet with a beat held in the output register.
    rdy_level = 1'b0;
    @(posedge clk);
    #1;
    start_op(1);
    send_beat(16'h5A5A, 2'b11, 1'b0, 1'b0);
    @(negedge clk);
    check("inflight_valid", m_axis_tvalid, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_m_valid_last", {m_axis_tvalid, m_axis_tlast}, 0);
    check("midrst_s_ready", s_axis_tready, 0);
    check("midrst_busy", operation_busy, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_level = 1'b1;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle_ready", s_axis_tready, 0);
      check("post_rst_m_valid", m_axis_tvalid, 0);
    end
    s_axis_tvalid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
